// File: rtl/flappy_pkg.sv
// Shared constants and types for the flappy playfield blocks.
// Optional feature macro used by pipe_scroller: PIPE_SPEEDUP_EN.
package flappy_pkg;

  localparam int COLS_DEF     = 16;
  localparam int ROWS_DEF     = 8;
  localparam int BIRD_COL_DEF = 4;

  typedef logic [ROWS_DEF-1:0] column_t;

  // Fibonacci taps at bits 7, 5, 4 and 3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Ticks per shift after reset, and how many spawns pass between speedups.
  localparam int SPEED_PERIOD_INIT = 4;
  localparam int SPEEDUP_INTERVAL  = 8;

endpackage

// File: rtl/pipe_scroller_if.sv
// Handshake and display bundle between the game timer/control and pipe_scroller.
interface pipe_scroller_if
  import flappy_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
);
  logic                      tick;
  logic                      lose;
  logic [COLS-1:0][ROWS-1:0] grid;
  logic [ROWS-1:0]           green_position;
  logic                      spawn;
  logic                      frozen;

  modport master (
    output tick, lose,
    input  grid, green_position, spawn, frozen
  );

  modport slave (
    input  tick, lose,
    output grid, green_position, spawn, frozen
  );
endinterface

// File: rtl/pipe_lfsr.sv
// 8-bit Fibonacci LFSR that steps only when asked; feeds pipe gap placement.
module pipe_lfsr
  import flappy_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  output logic [7:0] value
);

  logic [7:0] value_q;
  logic [7:0] value_d;

  // Next value: shift left, feed back the parity of the tapped bits.
  always_comb begin
    value_d = value_q;
    if (advance) begin
      value_d = {value_q[6:0], ^(value_q & LFSR_TAPS)};
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) value_q <= SEED;
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/pipe_scroller.sv
// Scrolling pipe field for the 16x8 LED playfield.
// Optional tick divider with progressive speedup: define PIPE_SPEEDUP_EN.
module pipe_scroller
  import flappy_pkg::*;
#(
  parameter int         COLS     = COLS_DEF,
  parameter int         ROWS     = ROWS_DEF,
  parameter int         BIRD_COL = BIRD_COL_DEF,
  parameter int         SPACING  = 4,
  parameter int         GAP      = 3,
  parameter logic [7:0] SEED     = 8'hA5
) (
  input  logic            clk,
  input  logic            reset,
  pipe_scroller_if.slave  bus
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(SPACING);
  localparam logic [RW-1:0] GAP_LIMIT = RW'(ROWS - GAP);

  logic [COLS-1:0][ROWS-1:0] grid_q, grid_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      spawn_q, spawn_d;
  logic                      frozen_q, frozen_d;

  logic [7:0]      lfsr_value;
  logic            lfsr_advance;
  logic            tick_ok;
  logic            shift;
  logic            spawning;
  logic [RW-1:0]   gap_raw;
  logic [RW-1:0]   gap_row;
  logic [ROWS-1:0] pipe_col;
  logic            unused_lfsr_bits;

  pipe_lfsr #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (lfsr_advance),
    .value   (lfsr_value)
  );

  assign unused_lfsr_bits = ^lfsr_value[7:RW];

  // A tick counts only while running; lose on the same edge wins over the tick.
  assign tick_ok  = bus.tick & ~bus.lose & ~frozen_q;
  assign spawning = shift & (cnt_q == '0);

`ifdef PIPE_SPEEDUP_EN
  localparam int SW = $clog2(SPEEDUP_INTERVAL);

  logic [2:0]    period_q, period_d;
  logic [2:0]    div_q, div_d;
  logic [SW-1:0] nspawn_q, nspawn_d;

  // Divider: shift on the period-th accepted tick; shorten period every SPEEDUP_INTERVAL spawns.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a value unassigned (no latch).
    period_d = period_q;
    div_d    = div_q;
    nspawn_d = nspawn_q;
    shift    = 1'b0;
    if (tick_ok) begin
      if (div_q == period_q - 3'd1) begin
        shift = 1'b1;
        div_d = '0;
      end else begin
        div_d = div_q + 3'd1;
      end
    end
    if (spawning) begin
      nspawn_d = nspawn_q + 1'b1;
      if (nspawn_q == SW'(SPEEDUP_INTERVAL - 1) && period_q > 3'd1) begin
        period_d = period_q - 3'd1;
        div_d    = '0;
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q <= 3'(SPEED_PERIOD_INIT);
      div_q    <= '0;
      nspawn_q <= '0;
    end else begin
      period_q <= period_d;
      div_q    <= div_d;
      nspawn_q <= nspawn_d;
    end
  end
`else
  // Without the divider every accepted tick shifts.
  assign shift = tick_ok;
`endif

  // Pipe column: solid except for GAP open rows starting at a folded LFSR-derived row.
  always_comb begin
    gap_raw  = lfsr_value[RW-1:0];
    gap_row  = (gap_raw <= GAP_LIMIT) ? gap_raw : gap_raw - GAP_LIMIT;
    pipe_col = '1;
    for (int i = 0; i < ROWS; i++) begin
      if (i >= int'(gap_row) && i < int'(gap_row) + GAP) pipe_col[i] = 1'b0;
    end
  end

  // Shift, spawn counter and freeze latch next-state.
  always_comb begin
    grid_d       = grid_q;
    cnt_d        = cnt_q;
    spawn_d      = 1'b0;
    lfsr_advance = 1'b0;
    frozen_d     = frozen_q | bus.lose;
    if (shift) begin
      for (int c = 0; c < COLS - 1; c++) grid_d[c] = grid_q[c+1];
      if (spawning) begin
        grid_d[COLS-1] = pipe_col;
        cnt_d          = CW'(SPACING - 1);
        lfsr_advance   = 1'b1;
        spawn_d        = 1'b1;
      end else begin
        grid_d[COLS-1] = '0;
        cnt_d          = cnt_q - 1'b1;
      end
    end
  end

  // Field state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grid_q   <= '0;
      cnt_q    <= '0;
      spawn_q  <= 1'b0;
      frozen_q <= 1'b0;
    end else begin
      grid_q   <= grid_d;
      cnt_q    <= cnt_d;
      spawn_q  <= spawn_d;
      frozen_q <= frozen_d;
    end
  end

  assign bus.grid           = grid_q;
  assign bus.green_position = grid_q[BIRD_COL];
  assign bus.spawn          = spawn_q;
  assign bus.frozen         = frozen_q;

endmodule

// File: doc/pipe_scroller.md
# pipe_scroller

Upstream feeder for the game-control stage. Generates the scrolling green pipe field on the 16x8 LED playfield. Shifts pipe columns from the right edge toward column 0 on each advance tick, and inserts a new pipe with a pseudo-random gap at a fixed spacing. Presents the column under the bird as `green_position`, plus the whole grid for the display driver. Freezes when the game-control stage reports `lose`.

## Interface
Parameters:
- `COLS`, 16, playfield columns
- `ROWS`, 8, playfield rows (bits per column)
- `BIRD_COL`, 4, column index exported as `green_position`
- `SPACING`, 4, shifts between pipe insertions (>=2)
- `GAP`, 3, open rows per pipe (1..ROWS-1)
- `SEED`, 8'hA5, LFSR reset value (nonzero)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `tick`  in  1  single-cycle advance strobe from the game timer
- `lose`  in  1  game-over level from the game-control stage
- `grid`  out  [COLS-1:0][ROWS-1:0]  pipe field, 1 = green LED lit
- `green_position`  out  ROWS  equals `grid[BIRD_COL]`
- `spawn`  out  1  one-cycle pulse on the cycle a new pipe column is written
- `frozen`  out  1  field halted after `lose`

## Operation
- Reset values: `grid` all 0, `green_position` 0, `spawn` 0, `frozen` 0, LFSR = `SEED`, spawn counter 0, speed state as described under Configuration.
- Freeze latch: `frozen` is set on any clock edge where `lose`=1. It stays set until `reset`. While frozen, `tick` is ignored, and `grid` and the LFSR hold.
- Shift event (tick accepted, not frozen, divider expired):
  - `grid[c] <= grid[c+1]` for c < COLS-1.
  - Column COLS-1 receives the inserted column.
  - Column 0 is discarded.
- Spawn counter:
  - If the counter is 0: insert a pipe, reload the counter to SPACING-1, advance the LFSR, pulse `spawn`.
  - Otherwise: insert all-zero, decrement the counter.
- Pipe column: all ones except rows `gap_row` .. `gap_row+GAP-1`, which are 0.
- Gap row:
  - Let r = LFSR low $clog2(ROWS) bits.
  - `gap_row` = r if r <= ROWS-GAP, else r-(ROWS-GAP).
- LFSR: 8-bit Fibonacci, feedback = b7^b5^b4^b3, next = {lfsr[6:0], fb}. It advances only on a spawn. It never reaches 0 from a nonzero seed.
- Width rules:
  - Spawn counter: $clog2(SPACING) bits.
  - `gap_row` arithmetic: unsigned at $clog2(ROWS) bits, no wrap past ROWS-1.

## Timing
- `grid`, `spawn` and `frozen` are registered. `green_position` is a combinational slice of the registered `grid`, so it has zero added latency.
- Tick sampled high at edge N produces a shifted `grid` visible after edge N. `spawn` is high for the cycle following edge N.
- Simultaneous `tick`=1 and `lose`=1 on the same edge: no shift occurs and `frozen` sets.
- A tick arriving while `reset` is asserted is ignored.
- Deasserting `reset` mid-game restarts the field from empty. The first accepted shift spawns the pipe from `SEED`.
- A pipe inserted at COLS-1 reaches `BIRD_COL` after COLS-1-BIRD_COL further shifts (11 with defaults).
- Consecutive ticks on back-to-back cycles are each honoured. No tick is dropped unless the stage is frozen or the divider has not expired.

## Configuration
- `PIPE_SPEEDUP_EN` defined:
  - A tick divider requires `period` accepted ticks per shift.
  - `period` resets to 4.
  - `period` decrements by 1 after every 8th spawn, with a floor of 1.
  - The divider count resets to 0 whenever `period` changes.
- Not defined: no divider or period logic; every accepted tick shifts (period fixed at 1).

## Structure
- Shared package `flappy_pkg` holds:
  - `COLS_DEF`, `ROWS_DEF`, `BIRD_COL_DEF`
  - `typedef logic [ROWS-1:0] column_t`
  - LFSR tap constant
  - Initial speed period (4) and speedup interval (8)
- One sub-module, `pipe_lfsr`: 8-bit LFSR with `clk`, `reset`, `advance`, and `value` outputs.
- Grid shifting, spawn counter, freeze latch and divider stay in the top module.

## Test plan
- Reset then first tick (defaults, macro off) -> `grid[15]`=8'b00011111, `spawn`=1 for one cycle, `grid[14:0]`=0.
- Four more ticks -> three zero columns, then `grid[15]`=8'b11100011 (LFSR 8'h4A, gap_row 2); `spawn` pulses only on the 1st and 5th ticks.
- 11 ticks after the first spawn -> `green_position`=8'b00011111 and matches `grid[4]` every cycle.
- `lose`=1 asserted together with a tick -> `grid` unchanged, `frozen`=1; 10 further ticks leave `grid` and `green_position` constant.
- Async `reset` pulse between clock edges mid-game -> `grid`=0, `frozen`=0 before the next edge; the next tick reproduces 8'b00011111.
- Macro on, 8 ticks after reset -> exactly 2 shifts; after 8 spawns, shifts occur every 3 ticks.
